// File: rtl/wb_sram_slave_pkg.sv
// Shared definitions for the Wishbone classic responder in front of a synchronous SRAM.
// Holds the FSM state encoding, the wait-state limit and the window-decode helper.
package wb_sram_slave_pkg;

    typedef enum logic [1:0] {
        WBS_IDLE   = 2'd0,
        WBS_ACCESS = 2'd1,
        WBS_WAIT   = 2'd2,
        WBS_RESP   = 2'd3
    } wbs_state_t;

    localparam int WBS_MAX_WAIT_STATES = 7;

    // The span is 33 bits wide so that a window covering all 4 GiB still compares correctly.
    function automatic logic wbs_in_window(input logic [31:0] offset,
                                           input logic [1:0]  adr_lsb,
                                           input int          addr_width);
        logic [32:0] span;
        span = 33'd4 << addr_width;
        return ({1'b0, offset} < span) && (adr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/wb_sram_slave.sv
// Wishbone classic responder that maps a BASE_ADDR window onto a single-port synchronous SRAM.
// Each transfer runs IDLE -> ACCESS -> [WAIT] -> RESP, with registered ack/err.
module wb_sram_slave
    import wb_sram_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          ADDR_WIDTH  = 20,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    output logic [3:0]            sram_be,
    input  logic [31:0]           sram_rdata
);

    localparam int WAIT_CLAMPED = (WAIT_STATES > WBS_MAX_WAIT_STATES) ? WBS_MAX_WAIT_STATES
                                                                      : WAIT_STATES;
    localparam logic [2:0] WAIT_LOAD = 3'((WAIT_CLAMPED > 0) ? WAIT_CLAMPED - 1 : 0);

    wbs_state_t            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [31:0]           rdat_q, rdat_d;
    logic                  sram_ce_q, sram_ce_d;
    logic                  sram_we_q, sram_we_d;
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [31:0]           sram_wdata_q, sram_wdata_d;
    logic [3:0]            sram_be_q, sram_be_d;
    logic [31:0]           offset;
    logic                  in_range;

    always_comb begin
        offset       = wb_adr_i - BASE_ADDR;
        in_range     = wbs_in_window(offset, wb_adr_i[1:0], ADDR_WIDTH);
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        rdat_d       = rdat_q;
        sram_ce_d    = 1'b0;
        sram_we_d    = sram_we_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_be_d    = sram_be_q;

        case (state_q)
            WBS_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    we_d = wb_we_i;
                    if (in_range) begin
                        state_d      = WBS_ACCESS;
                        sram_ce_d    = 1'b1;
                        sram_we_d    = wb_we_i;
                        sram_addr_d  = offset[ADDR_WIDTH+1:2];
                        sram_wdata_d = wb_dat_i;
                        sram_be_d    = wb_we_i ? wb_sel_i : 4'b1111;
                    end else begin
                        state_d = WBS_RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            // Dropping cyc abandons the transfer; stb is deliberately not looked at here.
            WBS_ACCESS: begin
                if (!wb_cyc_i) begin
                    state_d = WBS_IDLE;
                end else if (WAIT_CLAMPED == 0) begin
                    state_d = WBS_RESP;
                    ack_d   = 1'b1;
                end else begin
                    state_d = WBS_WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            WBS_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = WBS_IDLE;
                end else if (cnt_q == 3'd0) begin
                    state_d = WBS_RESP;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WBS_RESP: begin
                state_d = WBS_IDLE;
                if (ack_q && !we_q) begin
                    rdat_d = sram_rdata;
                end
            end
            default: state_d = WBS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WBS_IDLE;
            cnt_q        <= 3'd0;
            we_q         <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            rdat_q       <= 32'h0;
            sram_ce_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= 32'h0;
            sram_be_q    <= 4'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdat_q       <= rdat_d;
            sram_ce_q    <= sram_ce_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_be_q    <= sram_be_d;
        end
    end

    // Read data is passed straight through during the ack cycle, then held in rdat_q.
    assign wb_dat_o   = (state_q == WBS_RESP && ack_q && !we_q) ? sram_rdata : rdat_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign sram_ce    = sram_ce_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_be    = sram_be_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: two instances (0 and 3 wait states), each with a behavioural SRAM,
// driven by a Wishbone master whose expected responses go through a scoreboard queue.
module tb_wb_sram_slave;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    logic        clk;
    logic        rst_n;
    logic        cyc0, stb0, cyc3, stb3;
    logic        bus_we;
    logic [31:0] bus_adr, bus_dat;
    logic [3:0]  bus_sel;

    logic [31:0] dat0, dat3, rd0, rd3, wd0, wd3;
    logic        ack0, err0, ack3, err3, ce0, ce3, swe0, swe3;
    logic [19:0] a0, a3;
    logic [3:0]  be0, be3;

    bit          use3 = 1'b0;
    int          cycle = 0;
    int          total = 0;
    int          bad = 0;
    int          ce_count = 0;
    logic [19:0] last_ce_addr;
    logic [3:0]  last_ce_be;
    logic        last_ce_we;
    resp_t       exp_q[$];
    resp_t       obs_q[$];

    logic [31:0] mem0 [logic [19:0]];
    logic [31:0] mem3 [logic [19:0]];

    wb_sram_slave #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_we_i(bus_we), .wb_adr_i(bus_adr),
        .wb_dat_i(bus_dat), .wb_sel_i(bus_sel), .wb_dat_o(dat0), .wb_ack_o(ack0),
        .wb_err_o(err0), .sram_ce(ce0), .sram_we(swe0), .sram_addr(a0),
        .sram_wdata(wd0), .sram_be(be0), .sram_rdata(rd0)
    );

    wb_sram_slave #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(cyc3), .wb_stb_i(stb3), .wb_we_i(bus_we), .wb_adr_i(bus_adr),
        .wb_dat_i(bus_dat), .wb_sel_i(bus_sel), .wb_dat_o(dat3), .wb_ack_o(ack3),
        .wb_err_o(err3), .sram_ce(ce3), .sram_we(swe3), .sram_addr(a3),
        .sram_wdata(wd3), .sram_be(be3), .sram_rdata(rd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural sram_sp models: one-cycle read latency, byte-enabled write.
    always @(posedge clk) begin
        logic [31:0] w;
        if (ce0) begin
            w = mem0.exists(a0) ? mem0[a0] : 32'h0;
            if (swe0) begin
                for (int b = 0; b < 4; b++) if (be0[b]) w[8*b +: 8] = wd0[8*b +: 8];
                mem0[a0] = w;
            end else begin
                rd0 <= w;
            end
        end
    end

    always @(posedge clk) begin
        logic [31:0] w;
        if (ce3) begin
            w = mem3.exists(a3) ? mem3[a3] : 32'h0;
            if (swe3) begin
                for (int b = 0; b < 4; b++) if (be3[b]) w[8*b +: 8] = wd3[8*b +: 8];
                mem3[a3] = w;
            end else begin
                rd3 <= w;
            end
        end
    end

    // Monitor of the currently selected instance: logs SRAM strobes and every ack/err.
    always @(negedge clk) begin
        if (rst_n) begin
            if (use3 ? ce3 : ce0) begin
                ce_count++;
                last_ce_addr = use3 ? a3 : a0;
                last_ce_be   = use3 ? be3 : be0;
                last_ce_we   = use3 ? swe3 : swe0;
            end
            if (use3 ? (ack3 || err3) : (ack0 || err0)) begin
                obs_q.push_back('{is_err: (use3 ? err3 : err0),
                                  data: (use3 ? dat3 : dat0), cyc: cycle});
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_req(input logic c, input logic s);
        if (use3) begin
            cyc3 = c;
            stb3 = s;
        end else begin
            cyc0 = c;
            stb0 = s;
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_obs(output bit got);
        int k;
        got = 0;
        k   = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            #1;
            k++;
            if (obs_q.size() != 0) got = 1;
        end
    endtask

    // Caller is #1 after a rising edge; returns #1 after the edge following the response.
    task automatic run_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input bit exp_err,
                            input logic [31:0] exp_data,
                            output resp_t e, output resp_t o, output bit got);
        int t0;
        bus_we  = we;
        bus_adr = adr;
        bus_dat = dat;
        bus_sel = sel;
        set_req(1'b1, 1'b1);
        t0 = cycle;
        exp_q.push_back('{is_err: exp_err, data: exp_data,
                          cyc: exp_err ? t0 + 1 : t0 + 2 + (use3 ? 3 : 0)});
        wait_obs(got);
        e = exp_q.pop_front();
        if (got) o = obs_q.pop_front();
        else     o = '{is_err: 1'b0, data: 32'h0, cyc: -1};
        sync();
        set_req(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        use3    = 1'b0;
        bus_we  = 1'b1;
        bus_adr = 32'h8000_0010;
        bus_dat = 32'h1234_5678;
        bus_sel = 4'hF;
        cyc0 = 1'b1; stb0 = 1'b1; cyc3 = 1'b1; stb3 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({ack0, err0, dat0, ce0, swe0, a0, wd0, be0} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outs0: got ack=%b err=%b dat=%h ce=%b we=%b adr=%h wd=%h be=%h, want all 0",
                     ack0, err0, dat0, ce0, swe0, a0, wd0, be0);
        end
        total++;
        if ({ack3, err3, dat3, ce3, swe3, a3, wd3, be3} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outs3: got ack=%b err=%b dat=%h ce=%b we=%b adr=%h wd=%h be=%h, want all 0",
                     ack3, err3, dat3, ce3, swe3, a3, wd3, be3);
        end
        cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
        sync();
        rst_n = 1'b1;
    endtask

    task automatic test_read_write();
        resp_t e, o;
        bit    got;
        int    ce_before;
        use3 = 1'b0;
        run_xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, e, o, got);
        total++;
        if (!got || o.is_err || o.cyc != e.cyc) begin
            bad++;
            $display("[TB] FAIL wr_dead: got resp=%b err=%b cyc=%0d, want resp=1 err=0 cyc=%0d",
                     got, o.is_err, o.cyc, e.cyc);
        end
        ce_before = ce_count;
        run_xfer(1'b0, 32'h8000_0010, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, e, o, got);
        total++;
        if (!got || o.is_err || o.cyc != e.cyc || o.data !== e.data) begin
            bad++;
            $display("[TB] FAIL rd_dead: got resp=%b err=%b data=%h cyc=%0d, want err=0 data=%h cyc=%0d",
                     got, o.is_err, o.data, o.cyc, e.data, e.cyc);
        end
        total++;
        if (last_ce_addr !== 20'd4) begin
            bad++;
            $display("[TB] FAIL rd_sram_addr: got %h want 00004", last_ce_addr);
        end
        total++;
        if (ce_count - ce_before != 1) begin
            bad++;
            $display("[TB] FAIL rd_ce_pulses: got %0d want 1", ce_count - ce_before);
        end
        repeat (2) @(negedge clk);
        total++;
        if (dat0 !== 32'hDEAD_BEEF) begin
            bad++;
            $display("[TB] FAIL rd_hold: got %h want deadbeef", dat0);
        end
        sync();
    endtask

    task automatic test_byte_write();
        resp_t e, o;
        bit    got;
        int    ce_before;
        use3 = 1'b0;
        run_xfer(1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, e, o, got);
        run_xfer(1'b1, 32'h8000_0020, 32'h0000_AB00, 4'b0010, 1'b0, 32'h0, e, o, got);
        total++;
        if (!got || o.is_err || o.cyc != e.cyc) begin
            bad++;
            $display("[TB] FAIL byte_wr: got resp=%b err=%b cyc=%0d, want resp=1 err=0 cyc=%0d",
                     got, o.is_err, o.cyc, e.cyc);
        end
        run_xfer(1'b0, 32'h8000_0020, 32'h0, 4'hF, 1'b0, 32'hFFFF_ABFF, e, o, got);
        total++;
        if (!got || o.is_err || o.cyc != e.cyc || o.data !== e.data) begin
            bad++;
            $display("[TB] FAIL byte_rd: got resp=%b data=%h cyc=%0d, want data=%h cyc=%0d",
                     got, o.data, o.cyc, e.data, e.cyc);
        end
        ce_before = ce_count;
        run_xfer(1'b1, 32'h8000_0020, 32'h1234_5678, 4'b0000, 1'b0, 32'h0, e, o, got);
        total++;
        if (!got || o.is_err || o.cyc != e.cyc || ce_count - ce_before != 1
            || last_ce_be !== 4'h0 || last_ce_we !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sel0_wr: got resp=%b cyc=%0d ce=%0d be=%h we=%b, want cyc=%0d ce=1 be=0 we=1",
                     got, o.cyc, ce_count - ce_before, last_ce_be, last_ce_we, e.cyc);
        end
        run_xfer(1'b0, 32'h8000_0020, 32'h0, 4'hF, 1'b0, 32'hFFFF_ABFF, e, o, got);
        total++;
        if (!got || o.is_err || o.data !== e.data) begin
            bad++;
            $display("[TB] FAIL sel0_rd: got resp=%b data=%h, want data=%h", got, o.data, e.data);
        end
    endtask

    task automatic test_error();
        resp_t e, o;
        bit    got;
        int    ce_before;
        use3      = 1'b0;
        ce_before = ce_count;
        run_xfer(1'b0, 32'h8040_0000, 32'h0, 4'hF, 1'b1, 32'h0, e, o, got);
        total++;
        if (!got || !o.is_err || o.cyc != e.cyc) begin
            bad++;
            $display("[TB] FAIL err_range: got resp=%b err=%b cyc=%0d, want err=1 cyc=%0d",
                     got, o.is_err, o.cyc, e.cyc);
        end
        run_xfer(1'b1, 32'h8000_0002, 32'h5555_5555, 4'hF, 1'b1, 32'h0, e, o, got);
        total++;
        if (!got || !o.is_err || o.cyc != e.cyc) begin
            bad++;
            $display("[TB] FAIL err_align: got resp=%b err=%b cyc=%0d, want err=1 cyc=%0d",
                     got, o.is_err, o.cyc, e.cyc);
        end
        repeat (4) @(negedge clk);
        total++;
        if (ce_count != ce_before || obs_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL err_side: got ce=%0d extra_resp=%0d, want ce=0 extra_resp=0",
                     ce_count - ce_before, obs_q.size());
        end
        sync();
    endtask

    task automatic test_back_to_back();
        resp_t e, o;
        bit    got;
        int    t0;
        int    prev;
        use3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_xfer(1'b1, 32'h8000_0100 + 32'(4 * i), 32'hA500_0000 + 32'(i), 4'hF, 1'b0,
                     32'h0, e, o, got);
            total++;
            if (!got || o.is_err || o.cyc != e.cyc) begin
                bad++;
                $display("[TB] FAIL ws3_wr%0d: got resp=%b err=%b cyc=%0d, want cyc=%0d",
                         i, got, o.is_err, o.cyc, e.cyc);
            end
        end
        bus_we  = 1'b0;
        bus_adr = 32'h8000_0100;
        set_req(1'b1, 1'b1);
        t0   = cycle;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{is_err: 1'b0, data: 32'hA500_0000 + 32'(i), cyc: t0 + 5});
            wait_obs(got);
            e = exp_q.pop_front();
            if (got) o = obs_q.pop_front();
            else     o = '{is_err: 1'b0, data: 32'h0, cyc: -1};
            total++;
            if (!got || o.is_err || o.cyc != e.cyc || o.data !== e.data
                || (i > 0 && o.cyc - prev != 6)) begin
                bad++;
                $display("[TB] FAIL b2b_rd%0d: got resp=%b data=%h cyc=%0d gap=%0d, want data=%h cyc=%0d gap=6",
                         i, got, o.data, o.cyc, o.cyc - prev, e.data, e.cyc);
            end
            prev = o.cyc;
            sync();
            if (i < 3) begin
                bus_adr = 32'h8000_0100 + 32'(4 * (i + 1));
                t0      = cycle;
            end else begin
                set_req(1'b0, 1'b0);
            end
        end
    endtask

    task automatic test_abort();
        resp_t e, o;
        bit    got;
        use3    = 1'b1;
        bus_we  = 1'b0;
        bus_adr = 32'h8000_0104;
        set_req(1'b1, 1'b1);
        sync();
        sync();
        set_req(1'b0, 1'b0);
        sync();
        run_xfer(1'b0, 32'h8000_0108, 32'h0, 4'hF, 1'b0, 32'hA500_0002, e, o, got);
        total++;
        if (!got || o.is_err || o.cyc != e.cyc || o.data !== e.data) begin
            bad++;
            $display("[TB] FAIL abort_next: got resp=%b err=%b data=%h cyc=%0d, want data=%h cyc=%0d",
                     got, o.is_err, o.data, o.cyc, e.data, e.cyc);
        end
    endtask

    task automatic test_reset_mid();
        resp_t e, o;
        bit    got;
        use3    = 1'b0;
        bus_we  = 1'b0;
        bus_adr = 32'h8000_0020;
        set_req(1'b1, 1'b1);
        sync();
        total++;
        if (ce0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_ce: got %b want 1", ce0);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({ack0, err0, dat0, ce0, swe0, a0, wd0, be0, ack3, err3, ce3} !== '0) begin
            bad++;
            $display("[TB] FAIL mid_reset: got ack=%b err=%b ce=%b dat=%h adr=%h, want all 0",
                     ack0, err0, ce0, dat0, a0);
        end
        set_req(1'b0, 1'b0);
        sync();
        rst_n = 1'b1;
        run_xfer(1'b0, 32'h8000_0010, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, e, o, got);
        total++;
        if (!got || o.is_err || o.cyc != e.cyc || o.data !== e.data) begin
            bad++;
            $display("[TB] FAIL post_reset_rd: got resp=%b data=%h cyc=%0d, want data=%h cyc=%0d",
                     got, o.data, o.cyc, e.data, e.cyc);
        end
    endtask

    initial begin
        $display("[TB] starting wb_sram_slave bench");
        test_reset();
        test_read_write();
        test_byte_write();
        test_error();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
